// File: rtl/digit_serial_adder.sv
// Signed adder that processes one D-bit digit per cycle under valid/ready handshakes.
// Define SATURATION_EN to clamp Sum to the signed range when Overflow is set.
module digit_serial_adder #(
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Overflow,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int M  = N / D;
    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST = KW'(M - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT state;
    stateT stateNext;

    logic [N-1:0]  aReg;
    logic [N-1:0]  bReg;
    logic [N-1:0]  sumReg;
    logic [KW-1:0] k;
    logic [OW-1:0] off;
    logic          carry;
    logic          coutReg;
    logic          ovfReg;
    logic [D:0]    digSum;
    logic          accept;
    logic          lastDigit;
    logic          ovfNext;

    assign accept    = (state == IDLE) && in_valid;
    assign lastDigit = (state == RUN) && (k == LAST);

    // off tracks k*D so the digit select needs no multiplier
    assign digSum = {1'b0, aReg[off +: D]}
                  + {1'b0, bReg[off +: D]}
                  + (D+1)'(carry);

    assign ovfNext = (aReg[N-1] == bReg[N-1])
                  && (digSum[D-1] != aReg[N-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (in_valid) stateNext = RUN;
            RUN:     if (k == LAST) stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aReg    <= '0;
            bReg    <= '0;
            sumReg  <= '0;
            carry   <= 1'b0;
            coutReg <= 1'b0;
            ovfReg  <= 1'b0;
            k       <= '0;
            off     <= '0;
        end else if (accept) begin
            aReg    <= A;
            bReg    <= B;
            sumReg  <= '0;
            carry   <= Cin;
            coutReg <= 1'b0;
            ovfReg  <= 1'b0;
            k       <= '0;
            off     <= '0;
        end else if (state == RUN) begin
            sumReg[off +: D] <= digSum[D-1:0];
            carry <= digSum[D];
            k     <= k + 1'b1;
            off   <= off + OW'(D);
            if (lastDigit) begin
                coutReg <= digSum[D];
                ovfReg  <= ovfNext;
`ifdef SATURATION_EN
                if (ovfNext) begin
                    sumReg <= {aReg[N-1], {(N-1){~aReg[N-1]}}};
                end
`endif
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Sum       = sumReg;
    assign Cout      = coutReg;
    assign Overflow  = ovfReg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed corner cases plus random traffic
// scored against an arithmetic model of signed addition.
module tb_digit_serial_adder;

    localparam int N   = 32;
    localparam int D   = 8;
    localparam int LAT = N / D;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic [N-1:0] Sum;
    logic         Cout;
    logic         Overflow;
    logic         out_valid;
    logic         out_ready;

    int nCmp = 0;
    int nErr = 0;
    int cyc  = 0;

    typedef struct packed {
        logic [N-1:0] s;
        logic         co;
        logic         ov;
    } resT;

    always #5 clk = ~clk;

    digit_serial_adder #(.N(N), .D(D)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .Cin(Cin),
        .Sum(Sum),
        .Cout(Cout),
        .Overflow(Overflow),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    function automatic resT model(logic [N-1:0] a, logic [N-1:0] b, logic c);
        resT    r;
        longint s;
        longint lim;
        logic [N:0] u;
        lim  = longint'(1) << (N - 1);
        s    = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        u    = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        r.co = u[N];
        r.s  = u[N-1:0];
        r.ov = (s > lim - 1) || (s < -lim);
`ifdef SATURATION_EN
        if (r.ov) r.s = (s < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    resT q[$];
    int  acceptCyc = 0;
    bit  waitFirst = 0;
    bit  postHs    = 0;
    bit  postRst   = 0;

    always @(negedge clk) begin
        cyc++;
        if (postRst) begin
            check("reset out_valid", 32'(out_valid), 0);
            check("reset Sum", Sum, 0);
            check("reset Cout", 32'(Cout), 0);
            check("reset Overflow", 32'(Overflow), 0);
            check("reset in_ready", 32'(in_ready), 1);
            postRst = 0;
        end
        if (postHs) begin
            check("idle in_ready", 32'(in_ready), 1);
            check("idle out_valid", 32'(out_valid), 0);
            postHs = 0;
        end
        if (rst) begin
            q.delete();
            waitFirst = 0;
            postRst   = 1;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    nCmp++;
                    nErr++;
                    $display("FAIL spurious out_valid: got 1 expected 0");
                end else begin
                    if (waitFirst) begin
                        check("latency", 32'(cyc - acceptCyc - 1), LAT);
                        waitFirst = 0;
                    end
                    check("Sum", Sum, q[0].s);
                    check("Cout", 32'(Cout), 32'(q[0].co));
                    check("Overflow", 32'(Overflow), 32'(q[0].ov));
                    check("in_ready in DONE", 32'(in_ready), 0);
                    if (out_ready) begin
                        void'(q.pop_front());
                        postHs = 1;
                    end
                end
            end else if (waitFirst) begin
                check("in_ready in RUN", 32'(in_ready), 0);
            end
            if (in_valid && in_ready) begin
                q.push_back(model(A, B, Cin));
                acceptCyc = cyc;
                waitFirst = 1;
            end
        end
    end

    task automatic doOp(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input int hold, input bit junk,
                        output resT r);
        int t;
        r        = '0;
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 50);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            nCmp++;
            nErr++;
            $display("FAIL result timeout: got no out_valid expected within %0d", LAT);
            return;
        end
        r.s  = Sum;
        r.co = Cout;
        r.ov = Overflow;
        if (junk) begin
            in_valid = 1'b1;
            Cin      = 1'b1;
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    function automatic logic [N-1:0] pick();
        logic [N-1:0] c [4];
        c[0] = 32'h00000000;
        c[1] = 32'hFFFFFFFF;
        c[2] = 32'h7FFFFFFF;
        c[3] = 32'h80000000;
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        resT r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        doOp(32'd20, 32'd30, 1'b0, 0, 0, r);
        check("dir add Sum", r.s, 32'd50);
        check("dir add Cout", 32'(r.co), 0);
        check("dir add Ovf", 32'(r.ov), 0);

        doOp(32'(-100), 32'(-423), 1'b0, 1, 0, r);
        check("dir neg Sum", r.s, 32'(-523));
        check("dir neg Cout", 32'(r.co), 1);
        check("dir neg Ovf", 32'(r.ov), 0);

        doOp(32'd2147483640, 32'd10, 1'b0, 0, 0, r);
        check("dir povf Ovf", 32'(r.ov), 1);
`ifdef SATURATION_EN
        check("dir povf Sum", r.s, 32'h7FFFFFFF);
`else
        check("dir povf Sum", r.s, 32'h80000002);
`endif

        doOp(32'(-2147483640), 32'(-10), 1'b0, 0, 0, r);
        check("dir novf Ovf", 32'(r.ov), 1);
        check("dir novf Cout", 32'(r.co), 1);
`ifdef SATURATION_EN
        check("dir novf Sum", r.s, 32'h80000000);
`else
        check("dir novf Sum", r.s, 32'h7FFFFFFE);
`endif

        doOp(32'hFFFFFFFF, 32'd0, 1'b1, 0, 0, r);
        check("dir cin Sum", r.s, 32'd0);
        check("dir cin Cout", 32'(r.co), 1);
        check("dir cin Ovf", 32'(r.ov), 0);

        doOp(32'd1000, 32'd2345, 1'b1, 5, 1, r);
        check("stall Sum", r.s, 32'd3346);

        A        = 32'd123;
        B        = 32'd456;
        Cin      = 1'b0;
        in_valid = 1'b1;
        do @(negedge clk); while (!in_ready);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        doOp(32'd40, 32'(-50), 1'b0, 0, 0, r);
        check("post rst Sum", r.s, 32'(-10));
        check("post rst Cout", 32'(r.co), 0);

        for (int i = 0; i < 150; i++) begin
            doOp(pick(), pick(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), bit'($urandom_range(0, 1)), r);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter N, default 32: operand/sum width in bits.
REQ-002 SHALL have parameter D, default 8: digit width processed per cycle; N SHALL be an integer multiple of D, with D <= N.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operands presented.
REQ-006 SHALL have port in_ready, output, 1: block idle and able to accept operands.
REQ-007 SHALL have port A, input, N: signed operand A.
REQ-008 SHALL have port B, input, N: signed operand B.
REQ-009 SHALL have port Cin, input, 1: carry-in added at bit 0.
REQ-010 SHALL have port Sum, output, N: signed result.
REQ-011 SHALL have port Cout, output, 1: carry out of bit N-1.
REQ-012 SHALL have port Overflow, output, 1: two's-complement signed overflow.
REQ-013 SHALL have port out_valid, output, 1: result valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts result.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE, with IDLE as the reset state.
REQ-016 In IDLE, in_ready SHALL be 1; when in_valid and in_ready are both 1 on an edge, the block SHALL latch A, B and Cin, clear the digit counter and carry register to Cin, and enter RUN.
REQ-017 Each RUN cycle SHALL add digit k (bits k*D+D-1..k*D) of A and B plus the carry register, write digit k of Sum, update the carry register and increment k.
REQ-018 When k = N/D-1 in RUN, the block SHALL write the final digit, register Cout and Overflow, and enter DONE.
REQ-019 Latency SHALL be exactly N/D cycles from the accepting edge to the first cycle with out_valid=1; for N=32, D=8 this is 4 cycles; for D=N it is 1 cycle.
REQ-020 Overflow SHALL be 1 iff A[N-1]==B[N-1] and the unsaturated Sum[N-1]!=A[N-1], with Cin included in the sum.
REQ-021 In DONE, out_valid SHALL be 1, and Sum, Cout and Overflow SHALL be held stable until the cycle after out_valid and out_ready are both 1; the block SHALL then enter IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid, A, B and Cin SHALL be ignored in those states.
REQ-023 out_valid SHALL be 0 in IDLE and RUN; out_ready SHALL be ignored outside DONE.
REQ-024 Sum SHALL show only partially written digits during RUN; the consumer SHALL sample it only when out_valid=1.
REQ-025 Acceptance and result handshakes SHALL NOT overlap: the next operand is accepted no earlier than the cycle after DONE exits.

Reset
REQ-026 When rst=1 at an edge, the block SHALL enter IDLE and set Sum=0, Cout=0, Overflow=0, out_valid=0 and in_ready=1 after that edge.
REQ-027 Reset SHALL take priority over all handshakes; an addition in RUN or a result pending in DONE SHALL be discarded, with no result produced.

Configuration
REQ-028 Macro SATURATION_EN SHALL select saturating arithmetic.
REQ-029 With SATURATION_EN defined and Overflow=1, Sum SHALL be 2^(N-1)-1 when A[N-1]=0 and -2^(N-1) when A[N-1]=1; Cout and Overflow SHALL be unaffected.
REQ-030 Without SATURATION_EN, Sum SHALL be the wrapped (A+B+Cin) mod 2^N.

Verification (N=32, D=8 unless stated)
REQ-031 The bench SHALL check A=20, B=30, Cin=0 -> Sum=50, Cout=0, Overflow=0, with out_valid exactly 4 cycles after acceptance.
REQ-032 The bench SHALL check A=-100, B=-423 -> Sum=-523, Cout=1, Overflow=0.
REQ-033 The bench SHALL check A=2147483640, B=10 -> Overflow=1, Sum=32'h80000002 without SATURATION_EN and 32'h7FFFFFFF with it; also A=-2147483640, B=-10 -> Overflow=1, Sum=32'h7FFFFFFE without SATURATION_EN and 32'h80000000 with it.
REQ-034 The bench SHALL check A=32'hFFFFFFFF, B=0, Cin=1 -> Sum=0, Cout=1, Overflow=0.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check that outputs stay stable, in_ready=0 and a presented in_valid is ignored; then raise out_ready and check IDLE on the next cycle.
REQ-036 The bench SHALL assert rst for 1 cycle during the second RUN cycle and check out_valid=0, Sum=0, in_ready=1, then check that a fresh 40+(-50) yields -10.
